// File: rtl/image_loader_if.sv
// Pixel-stream and classifier-core signal bundle for the double-buffered image loader.
// The slave modport is the loader's view; master is the environment driving it.
interface image_loader_if #(
    parameter int WD = 8
);
    logic          pix_valid;
    logic [WD-1:0] pix_data;
    logic          pix_ready;
    logic          go;
    logic          cena_image;
    logic [9:0]    aa_image;
    logic [WD-1:0] qa;
    logic          ready;
    logic          busy;
    logic [15:0]   frames_done;

    modport slave (
        input  pix_valid, pix_data, cena_image, aa_image, ready,
        output pix_ready, go, qa, busy, frames_done
    );

    modport master (
        output pix_valid, pix_data, cena_image, aa_image, ready,
        input  pix_ready, go, qa, busy, frames_done
    );
endinterface

// File: rtl/image_loader.sv
// Two-bank frame buffer: one bank fills from the pixel stream while the other
// is read by the classifier core; a small FSM launches the core on each full bank.
module image_loader #(
    parameter int WD   = 8,
    parameter int NPIX = 1024
) (
    input logic           clk,
    input logic           rst_n,
    image_loader_if.slave bus
);
    localparam int            AW       = $clog2(NPIX);
    localparam logic [AW-1:0] LAST_PTR = AW'(NPIX - 1);

    typedef enum logic [1:0] {
        BANK_EMPTY,
        BANK_FILLING,
        BANK_FULL,
        BANK_COMPUTING
    } bank_state_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_GO,
        ST_BUSY
    } fsm_state_t;

    bank_state_t   bank_q [2];
    bank_state_t   bank_d [2];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic          wr_sel_q, wr_sel_d;
    logic          rd_sel_q, rd_sel_d;
    fsm_state_t    state_q, state_d;
    logic [15:0]   frames_done_q, frames_done_d;
    logic [WD-1:0] qa_q;

    logic          pix_ready_c;
    logic          pix_accept;
    logic          launch_sel;

    logic [WD-1:0] mem [2][NPIX];

    assign pix_ready_c = (bank_q[wr_sel_q] == BANK_EMPTY) || (bank_q[wr_sel_q] == BANK_FILLING);
    assign pix_accept  = bus.pix_valid && pix_ready_c;

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        bank_d        = bank_q;
        wr_ptr_d      = wr_ptr_q;
        wr_sel_d      = wr_sel_q;
        rd_sel_d      = rd_sel_q;
        state_d       = state_q;
        frames_done_d = frames_done_q;
        launch_sel    = 1'b0;

        if (pix_accept) begin
            if (bank_q[wr_sel_q] == BANK_EMPTY) begin
                bank_d[wr_sel_q] = BANK_FILLING;
            end
            if (wr_ptr_q == LAST_PTR) begin
                bank_d[wr_sel_q] = BANK_FULL;
                wr_ptr_d         = '0;
                wr_sel_d         = ~wr_sel_q;
            end else begin
                wr_ptr_d = wr_ptr_q + AW'(1);
            end
        end

        // Fills alternate banks, so with both FULL the older one is the next write target.
        case (state_q)
            ST_IDLE: begin
                if (bank_q[0] == BANK_FULL || bank_q[1] == BANK_FULL) begin
                    if (bank_q[0] == BANK_FULL && bank_q[1] == BANK_FULL) begin
                        launch_sel = wr_sel_q;
                    end else begin
                        launch_sel = (bank_q[1] == BANK_FULL);
                    end
                    bank_d[launch_sel] = BANK_COMPUTING;
                    rd_sel_d           = launch_sel;
                    state_d            = ST_GO;
                end
            end
            ST_GO: state_d = ST_BUSY;
            ST_BUSY: begin
                if (bus.ready) begin
                    bank_d[rd_sel_q] = BANK_EMPTY;
                    frames_done_d    = frames_done_q + 16'd1;
                    state_d          = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bank_q[0]     <= BANK_EMPTY;
            bank_q[1]     <= BANK_EMPTY;
            wr_ptr_q      <= '0;
            wr_sel_q      <= 1'b0;
            rd_sel_q      <= 1'b0;
            state_q       <= ST_IDLE;
            frames_done_q <= '0;
            qa_q          <= '0;
        end else begin
            bank_q        <= bank_d;
            wr_ptr_q      <= wr_ptr_d;
            wr_sel_q      <= wr_sel_d;
            rd_sel_q      <= rd_sel_d;
            state_q       <= state_d;
            frames_done_q <= frames_done_d;
            if (!bus.cena_image) begin
                qa_q <= mem[rd_sel_q][bus.aa_image];
            end
        end
    end

    // NOTE: the pixel store has no reset; bank state alone decides whether its contents are valid.
    always_ff @(posedge clk) begin
        if (pix_accept) begin
            mem[wr_sel_q][wr_ptr_q] <= bus.pix_data;
        end
    end

    assign bus.pix_ready   = pix_ready_c;
    assign bus.go          = (state_q == ST_GO);
    assign bus.busy        = (state_q != ST_IDLE);
    assign bus.qa          = qa_q;
    assign bus.frames_done = frames_done_q;

endmodule

// File: tb/tb_image_loader.sv
// Directed bench for image_loader: core reads go through an expected-value queue
// checked by a monitor; control outputs are checked inline at the falling edge.
module tb_image_loader;
    logic clk = 1'b0;
    logic rst_n;

    int total = 0;
    int bad   = 0;

    logic [7:0] exp_q[$];

    localparam logic [7:0] KA = 8'h5A;
    localparam logic [7:0] KB = 8'hC3;
    localparam logic [7:0] KC = 8'h96;

    image_loader_if #(.WD(8)) bus ();

    image_loader #(.WD(8), .NPIX(1024)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] pix_val(input logic [9:0] addr, input logic [7:0] key);
        return addr[7:0] ^ key;
    endfunction

    // Monitor: a read issued at a rising edge is compared against the queue at the next falling edge.
    initial begin
        forever begin
            @(posedge clk);
            if (rst_n === 1'b1 && bus.cena_image === 1'b0) begin
                @(negedge clk);
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL qa_unexpected: got %0h with no expected value queued", bus.qa);
                end else begin
                    logic [7:0] e;
                    e = exp_q.pop_front();
                    if (bus.qa !== e) begin
                        bad++;
                        $display("FAIL qa_read: got %0h expected %0h (t=%0t)", bus.qa, e, $time);
                    end
                end
            end
        end
    end

    task automatic send_frame(input logic [7:0] key, input int n);
        for (int i = 0; i < n; i++) begin
            int guard;
            guard          = 0;
            bus.pix_valid  = 1'b1;
            bus.pix_data   = pix_val(i[9:0], key);
            while (bus.pix_ready !== 1'b1 && guard < 5000) begin
                @(negedge clk);
                guard++;
            end
            if (guard >= 5000) begin
                total++;
                bad++;
                $display("FAIL stream_stall: pixel %0d never accepted, pix_ready=%0b", i, bus.pix_ready);
                bus.pix_valid = 1'b0;
                return;
            end
            @(negedge clk);
        end
        bus.pix_valid = 1'b0;
    endtask

    task automatic core_read(input logic [9:0] addr, input logic [7:0] exp);
        exp_q.push_back(exp);
        bus.cena_image = 1'b0;
        bus.aa_image   = addr;
        @(negedge clk);
        bus.cena_image = 1'b1;
    endtask

    task automatic ready_pulse();
        bus.ready = 1'b1;
        @(negedge clk);
        bus.ready = 1'b0;
    endtask

    initial begin
        rst_n          = 1'b0;
        bus.pix_valid  = 1'b0;
        bus.pix_data   = '0;
        bus.cena_image = 1'b1;
        bus.aa_image   = '0;
        bus.ready      = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_pix_ready", bus.pix_ready, 1);
        check("rst_go", bus.go, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_qa", bus.qa, 0);
        check("rst_frames_done", bus.frames_done, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Single frame into bank 0, launch timing, reads, completion.
        send_frame(8'h00, 1024);
        check("f1_go_at_e0", bus.go, 0);
        check("f1_busy_at_e0", bus.busy, 0);
        check("f1_pix_ready_bank1", bus.pix_ready, 1);
        @(negedge clk);
        check("f1_go_e1", bus.go, 1);
        check("f1_busy_e1", bus.busy, 1);
        @(negedge clk);
        check("f1_go_e2", bus.go, 0);
        check("f1_busy_e2", bus.busy, 1);
        core_read(10'd37, 8'd37);
        core_read(10'd0, 8'd0);
        core_read(10'd1023, 8'hFF);
        ready_pulse();
        check("f1_busy_done", bus.busy, 0);
        check("f1_frames_done", bus.frames_done, 1);

        // Spurious ready while idle.
        ready_pulse();
        @(negedge clk);
        check("spur_frames_done", bus.frames_done, 1);
        check("spur_busy", bus.busy, 0);
        check("spur_go", bus.go, 0);

        // Reset mid-fill: outputs must clear without waiting for a clock edge.
        send_frame(8'h3C, 500);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_qa", bus.qa, 0);
        check("mid_rst_frames_done", bus.frames_done, 0);
        check("mid_rst_busy", bus.busy, 0);
        check("mid_rst_go", bus.go, 0);
        check("mid_rst_pix_ready", bus.pix_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_pix_ready", bus.pix_ready, 1);

        // Backpressure and ordering: A into bank 0, B into bank 1, third frame stalls.
        send_frame(KA, 1024);
        send_frame(KB, 1024);
        check("bp_pix_ready_low", bus.pix_ready, 0);
        check("bp_busy", bus.busy, 1);
        bus.pix_valid = 1'b1;
        bus.pix_data  = pix_val(10'd0, KC);
        repeat (3) @(negedge clk);
        check("bp_still_stalled", bus.pix_ready, 0);
        check("bp_no_go", bus.go, 0);
        bus.pix_valid = 1'b0;
        core_read(10'd0, pix_val(10'd0, KA));
        core_read(10'd37, pix_val(10'd37, KA));
        core_read(10'd500, pix_val(10'd500, KA));
        ready_pulse();
        check("ord_busy_idle", bus.busy, 0);
        check("ord_go_idle", bus.go, 0);
        check("ord_frames_done", bus.frames_done, 1);
        check("bp_pix_ready_freed", bus.pix_ready, 1);
        @(negedge clk);
        check("ord_go_b", bus.go, 1);
        @(negedge clk);
        check("ord_go_b_end", bus.go, 0);
        check("ord_busy_b", bus.busy, 1);
        core_read(10'd37, pix_val(10'd37, KB));
        core_read(10'd1023, pix_val(10'd1023, KB));

        // Frame C fills bank 0 while the core reads bank 1; last pixel coincides with ready.
        fork
            send_frame(KC, 1023);
            begin
                repeat (20) @(negedge clk);
                core_read(10'd200, pix_val(10'd200, KB));
            end
        join
        bus.pix_valid = 1'b1;
        bus.pix_data  = pix_val(10'd1023, KC);
        bus.ready     = 1'b1;
        @(negedge clk);
        bus.pix_valid = 1'b0;
        bus.ready     = 1'b0;
        check("sim_busy_idle", bus.busy, 0);
        check("sim_go_idle", bus.go, 0);
        check("sim_frames_done", bus.frames_done, 2);
        @(negedge clk);
        check("sim_go", bus.go, 1);
        check("sim_busy", bus.busy, 1);
        check("sim_frames_done_once", bus.frames_done, 2);
        core_read(10'd1023, pix_val(10'd1023, KC));
        core_read(10'd100, pix_val(10'd100, KC));
        ready_pulse();
        check("c_frames_done", bus.frames_done, 3);
        check("c_busy", bus.busy, 0);
        check("c_pix_ready", bus.pix_ready, 1);

        repeat (3) @(negedge clk);
        check("scoreboard_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/image_loader.md
IMAGE_LOADER -- requirements
Module: image_loader

Interface
REQ-001 SHALL have parameter WD, default 8, pixel data width, matching the `WD width used by the classifier core's conv1_image port.
REQ-002 SHALL have parameter NPIX, default 1024, pixels per frame (32x32 raster).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset; asynchronous and active-low.
REQ-005 SHALL have port pix_valid  input  1  upstream pixel valid.
REQ-006 SHALL have port pix_data  input  WD  upstream pixel, raster order.
REQ-007 SHALL have port pix_ready  output  1  loader can accept a pixel this cycle.
REQ-008 SHALL have port go  output  1  one-cycle start pulse to the classifier core.
REQ-009 SHALL have port cena_image  input  1  core read enable, active-low.
REQ-010 SHALL have port aa_image  input  10  core read address, 0..1023.
REQ-011 SHALL have port qa  output  WD  read data to core (conv1_image).
REQ-012 SHALL have port ready  input  1  core done pulse.
REQ-013 SHALL have port busy  output  1  a frame is launched and not yet completed.
REQ-014 SHALL have port frames_done  output  16  count of completed frames.

Function
REQ-015 SHALL hold two frame banks (bank 0, bank 1), each NPIX x WD; each bank is in exactly one state: EMPTY, FILLING, FULL or COMPUTING.
REQ-016 SHALL accept a pixel only on a rising edge where pix_valid && pix_ready.
REQ-017 SHALL write accepted pixels into the current write bank at a write pointer starting at 0, incrementing by 1 per accepted pixel.
REQ-018 SHALL, at the first accepted pixel of a frame, move the write bank EMPTY->FILLING.
REQ-019 SHALL, at the accepted pixel with pointer NPIX-1, move the write bank to FULL, clear the pointer to 0 and toggle the write-bank select.
REQ-020 SHALL drive pix_ready = 1 iff the current write bank is EMPTY or FILLING (combinational from registered state).
REQ-021 SHALL run the launch FSM with states IDLE, GO and BUSY.
REQ-022 SHALL transition IDLE->GO at an edge where a FULL bank exists; if both banks are FULL, the older (first filled) bank SHALL be selected. The selected bank becomes COMPUTING and is latched as the read bank.
REQ-023 SHALL drive go = 1 only in state GO, for exactly one cycle; GO->BUSY unconditionally.
REQ-024 SHALL transition BUSY->IDLE at an edge with ready = 1; at that edge the read bank SHALL become EMPTY and frames_done SHALL increment modulo 2^16.
REQ-025 SHALL ignore ready in IDLE and GO: no state change and no count.
REQ-026 SHALL drive busy = 1 in GO and BUSY, and 0 in IDLE.
REQ-027 SHALL, at an edge with cena_image = 0, register qa <= read_bank[aa_image] (1-cycle read latency); qa SHALL hold its value when cena_image = 1.
REQ-028 SHALL honour core reads in any FSM state, always using the last latched read bank (bank 0 after reset).
REQ-029 SHALL allow a pixel write and a core read to proceed in the same cycle (different banks); no stall.
REQ-030 SHALL, when ready and a second bank's final pixel occur at the same edge, apply both updates; the next go SHALL issue two edges later (BUSY->IDLE->GO).
REQ-031 SHALL, when a bank becomes FULL at edge E0 while IDLE, take IDLE->GO at E1, so that go is high from E1 to E2.

Reset
REQ-032 SHALL, on rst_n = 0, immediately set: both banks EMPTY, write pointer 0, write select 0, read bank 0, FSM IDLE, go 0, busy 0, qa 0, frames_done 0.
REQ-033 SHALL discard a partially filled or computing frame on reset mid-operation; bank memory contents need not be cleared.
REQ-034 SHALL leave pix_ready = 1 after reset release.

Verification
REQ-035 SHALL pass single frame: stream 1024 pixels with value = addr[7:0], last accepted at E0 -> go is high exactly during E1..E2; a core read at addr 37 returns qa = 37 one cycle later; ready pulse -> busy = 0 and frames_done = 1.
REQ-036 SHALL pass backpressure: 3 frames streamed continuously with no ready -> after 2048 pixels pix_ready = 0 and frame 3 stalls; a ready pulse frees bank 0, and pix_ready = 1 the following cycle.
REQ-037 SHALL pass ordering: two FULL banks, frames A then B -> the first go reads A data and the second go (after ready) reads B data.
REQ-038 SHALL pass simultaneous events: ready at the same edge as the 1024th pixel of the next frame -> IDLE, then go one cycle later, with frames_done incremented once.
REQ-039 SHALL pass spurious ready and reset: ready while IDLE -> frames_done unchanged; rst_n low mid-fill (pixel 500) -> all outputs reach reset values asynchronously, and the next frame starts at address 0.
